pwr_wake_sched: RTL and testbench

//  Round-robin wake-up sequencer for the power control subsystem. Takes per-peripheral

---
 rtl/pwr_wake_sched.sv | 154 +++++++++++++++
 tb/tb_pwr_wake_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_wake_sched.sv
// rtl/pwr_wake_sched.sv - round-robin wake-up sequencer with settle and gap timing
// Admits one peripheral wake at a time, holds its grant for a settle window, then idles for a gap.
module pwr_wake_sched #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sched_en,
    input  logic [N-1:0]  wake_req,
    input  logic [CW-1:0] settle_cyc,
    input  logic [CW-1:0] gap_cyc,
    output logic [N-1:0]  grant,
    output logic [N-1:0]  wake_done,
    output logic          busy,
    output logic [15:0]   wake_cnt,
    output logic [15:0]   abort_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GAP
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [CW-1:0] settle_left;
    logic [CW-1:0] gap_left;
    logic [CW-1:0] gap_lat;

    logic          arb_found;
    logic [PW-1:0] arb_idx;
    logic [PW-1:0] scan_idx;
    logic [N-1:0]  arb_onehot;
    logic [PW-1:0] ptr_next;
    logic [CW-1:0] eff_settle;

    // Rotating priority: scan upward from ptr, wrapping past N-1 back to 0.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        scan_idx   = '0;
        arb_onehot = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = PW'((int'(ptr) + i) % N);
            if (!arb_found && wake_req[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
        arb_onehot[arb_idx] = 1'b1;
        ptr_next   = (arb_idx == PW'(N - 1)) ? '0 : arb_idx + PW'(1);
        eff_settle = (settle_cyc == '0) ? CW'(1) : settle_cyc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            wake_done   <= '0;
            busy        <= 1'b0;
            wake_cnt    <= '0;
            abort_cnt   <= '0;
            ptr         <= '0;
            winner      <= '0;
            settle_left <= '0;
            gap_left    <= '0;
            gap_lat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    grant     <= '0;
                    wake_done <= '0;
                    if (sched_en && arb_found) begin
                        winner      <= arb_idx;
                        grant       <= arb_onehot;
                        // A one-cycle settle window completes in its first grant cycle.
                        wake_done   <= (eff_settle == CW'(1)) ? arb_onehot : '0;
                        settle_left <= eff_settle;
                        gap_lat     <= gap_cyc;
                        ptr         <= ptr_next;
                        state       <= SETTLE;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (settle_left == CW'(1)) begin
                        grant     <= '0;
                        wake_done <= '0;
                        if (wake_cnt != 16'hFFFF) begin
                            wake_cnt <= wake_cnt + 16'd1;
                        end
                        if (gap_lat != '0) begin
                            gap_left <= gap_lat;
                            state    <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!wake_req[winner]) begin
                        grant     <= '0;
                        wake_done <= '0;
                        if (abort_cnt != 16'hFFFF) begin
                            abort_cnt <= abort_cnt + 16'd1;
                        end
                        if (gap_lat != '0) begin
                            gap_left <= gap_lat;
                            state    <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        settle_left <= settle_left - CW'(1);
                        wake_done   <= (settle_left == CW'(2)) ? grant : '0;
                    end
                end

                GAP: begin
                    if (gap_left == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_left <= gap_left - CW'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    wake_done <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    if (N < 1) begin : g_bad_n
        $error("pwr_wake_sched needs N >= 1");
    end

    grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    done_in_grant_a: assert property (@(posedge clk) disable iff (rst) (wake_done & ~grant) == '0);
`endif

endmodule

// File: tb/tb_pwr_wake_sched.sv
// tb/tb_pwr_wake_sched.sv - scoreboard bench for the round-robin wake sequencer
module tb_pwr_wake_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sched_en = 1'b0;
    logic [3:0]  wake_req = '0;
    logic [7:0]  settle_cyc = '0;
    logic [7:0]  gap_cyc = '0;
    logic [3:0]  grant;
    logic [3:0]  wake_done;
    logic        busy;
    logic [15:0] wake_cnt;
    logic [15:0] abort_cnt;

    always #5 clk = ~clk;

    pwr_wake_sched #(.N(4), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en   (sched_en),
        .wake_req   (wake_req),
        .settle_cyc (settle_cyc),
        .gap_cyc    (gap_cyc),
        .grant      (grant),
        .wake_done  (wake_done),
        .busy       (busy),
        .wake_cnt   (wake_cnt),
        .abort_cnt  (abort_cnt)
    );

    typedef struct {
        logic [3:0] g;
        int         len;
        bit         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wake(input logic [3:0] g, input int len, input bit done);
        exp_t e;
        e.g = g;
        e.len = len;
        e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sched_en = 1'b0;
        wake_req = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_grant", grant, 0);
        check("rst_done", wake_done, 0);
        check("rst_busy", busy, 0);
        check("rst_wake_cnt", wake_cnt, 0);
        check("rst_abort_cnt", abort_cnt, 0);
    endtask

    // Monitor: each grant window pops one expectation and is checked for id, length and done cycle.
    bit         mon_on = 1'b0;
    bit         in_win = 1'b0;
    bit         bad_done = 1'b0;
    bit         grant_moved = 1'b0;
    int         win_len = 0;
    int         done_at = 0;
    logic [3:0] win_g = '0;
    exp_t       cur;

    always @(negedge clk) begin
        if (mon_on) begin
            if (grant !== 4'b0000) begin
                if (!in_win) begin
                    in_win = 1'b1;
                    win_len = 0;
                    done_at = 0;
                    bad_done = 1'b0;
                    grant_moved = 1'b0;
                    win_g = grant;
                    if (exp_q.size() == 0) begin
                        cur.g = 4'b0000;
                        cur.len = 0;
                        cur.done = 1'b0;
                        check("sb_unexpected_grant", grant, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("sb_grant", grant, cur.g);
                    end
                end
                win_len++;
                if (grant !== win_g) grant_moved = 1'b1;
                if (wake_done !== 4'b0000) begin
                    if (wake_done === grant && done_at == 0) done_at = win_len;
                    else bad_done = 1'b1;
                end
            end else begin
                if (wake_done !== 4'b0000) check("sb_done_without_grant", wake_done, 0);
                if (in_win) begin
                    in_win = 1'b0;
                    check("sb_len", win_len, cur.len);
                    check("sb_done_cycle", done_at, cur.done ? cur.len : 0);
                    check("sb_window_clean", {grant_moved, bad_done}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] rr_order [5];

    initial begin
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;
        rr_order[4] = 4'b0001;

        do_reset();
        mon_on = 1'b1;

        // Single wake, settle=3 gap=2; settle change mid-wake must not matter.
        settle_cyc = 8'd3;
        gap_cyc = 8'd2;
        sched_en = 1'b1;
        wake_req = 4'b0100;
        expect_wake(4'b0100, 3, 1'b1);
        tick();
        check("t1_grant_c1", grant, 4'b0100);
        check("t1_busy_c1", busy, 1);
        check("t1_done_c1", wake_done, 0);
        settle_cyc = 8'd7;
        tick();
        check("t1_done_c2", wake_done, 0);
        tick();
        check("t1_grant_c3", grant, 4'b0100);
        check("t1_done_c3", wake_done, 4'b0100);
        wake_req = 4'b0000;
        tick();
        check("t1_grant_gap1", grant, 0);
        check("t1_busy_gap1", busy, 1);
        tick();
        check("t1_busy_gap2", busy, 1);
        tick();
        check("t1_busy_idle", busy, 0);
        check("t1_wake_cnt", wake_cnt, 1);

        // Back-to-back with a held request: settle=2 gap=3, next grant 4 cycles after last grant.
        settle_cyc = 8'd2;
        gap_cyc = 8'd3;
        wake_req = 4'b0001;
        expect_wake(4'b0001, 2, 1'b1);
        expect_wake(4'b0001, 2, 1'b1);
        tick();
        check("t2b_grant_a", grant, 4'b0001);
        tick();
        check("t2b_done_a", wake_done, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2b_gap_busy", busy, 1);
            check("t2b_gap_grant", grant, 0);
        end
        tick();
        check("t2b_idle_busy", busy, 0);
        tick();
        check("t2b_grant_b", grant, 4'b0001);
        tick();
        check("t2b_done_b", wake_done, 4'b0001);
        wake_req = 4'b0000;
        tick();
        check("t2b_wake_cnt", wake_cnt, 3);

        // Round robin from ptr=0 with all requests held.
        do_reset();
        settle_cyc = 8'd1;
        gap_cyc = 8'd0;
        sched_en = 1'b1;
        wake_req = 4'b1111;
        for (int k = 0; k < 5; k++) expect_wake(rr_order[k], 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_rr_grant", grant, rr_order[k]);
            check("t2_rr_done", wake_done, rr_order[k]);
            if (k == 4) wake_req = 4'b0000;
            tick();
            check("t2_rr_idle_gap", grant, 0);
        end
        check("t2_wake_cnt", wake_cnt, 5);

        // Abort: request drops in the 2nd of 5 settle cycles.
        do_reset();
        settle_cyc = 8'd5;
        gap_cyc = 8'd0;
        sched_en = 1'b1;
        wake_req = 4'b0010;
        expect_wake(4'b0010, 2, 1'b0);
        tick();
        check("t3_grant_c1", grant, 4'b0010);
        tick();
        check("t3_grant_c2", grant, 4'b0010);
        wake_req = 4'b0000;
        tick();
        check("t3_grant_c3", grant, 0);
        check("t3_done_c3", wake_done, 0);
        check("t3_busy", busy, 0);
        check("t3_abort_cnt", abort_cnt, 1);
        check("t3_wake_cnt", wake_cnt, 0);

        // Zero settle behaves as one cycle.
        settle_cyc = 8'd0;
        wake_req = 4'b1000;
        expect_wake(4'b1000, 1, 1'b1);
        tick();
        check("t4_grant", grant, 4'b1000);
        check("t4_done", wake_done, 4'b1000);
        wake_req = 4'b0000;
        tick();
        check("t4_grant_off", grant, 0);
        check("t4_wake_cnt", wake_cnt, 1);

        // sched_en low blocks arbitration; dropping it mid-settle lets the wake finish.
        sched_en = 1'b0;
        settle_cyc = 8'd4;
        wake_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_grant", grant, 0);
            check("t5_no_busy", busy, 0);
        end
        sched_en = 1'b1;
        expect_wake(4'b0001, 4, 1'b1);
        tick();
        check("t5_grant_c1", grant, 4'b0001);
        sched_en = 1'b0;
        tick();
        tick();
        tick();
        check("t5_done_c4", wake_done, 4'b0001);
        wake_req = 4'b0000;
        tick();
        check("t5_end_grant", grant, 0);
        check("t5_end_busy", busy, 0);
        check("t5_wake_cnt", wake_cnt, 2);

        // Reset mid-settle clears everything, then arbitration restarts at ptr=0.
        sched_en = 1'b1;
        settle_cyc = 8'd5;
        wake_req = 4'b0100;
        expect_wake(4'b0100, 2, 1'b0);
        tick();
        check("t5r_grant_c1", grant, 4'b0100);
        tick();
        rst = 1'b1;
        wake_req = 4'b0000;
        tick();
        check("t5r_grant", grant, 0);
        check("t5r_done", wake_done, 0);
        check("t5r_busy", busy, 0);
        check("t5r_wake_cnt", wake_cnt, 0);
        check("t5r_abort_cnt", abort_cnt, 0);
        rst = 1'b0;
        settle_cyc = 8'd1;
        wake_req = 4'b1111;
        expect_wake(4'b0001, 1, 1'b1);
        tick();
        check("t5r_ptr0_grant", grant, 4'b0001);
        wake_req = 4'b0000;
        tick();
        check("t5r_wake_cnt_after", wake_cnt, 1);

        // Saturation of the completion counter.
        force dut.wake_cnt = 16'hFFFE;
        #1;
        release dut.wake_cnt;
        check("t6_preload", wake_cnt, 16'hFFFE);
        wake_req = 4'b0001;
        expect_wake(4'b0001, 1, 1'b1);
        tick();
        wake_req = 4'b0000;
        tick();
        check("t6_cnt_ffff", wake_cnt, 16'hFFFF);
        wake_req = 4'b0010;
        expect_wake(4'b0010, 1, 1'b1);
        tick();
        check("t6_grant2", grant, 4'b0010);
        wake_req = 4'b0000;
        tick();
        check("t6_cnt_hold", wake_cnt, 16'hFFFF);

        tick();
        tick();
        check("sb_queue_empty", exp_q.size(), 0);
        check("sb_window_closed", in_win, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
